// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin data/instruction arbiter onto a strobe/ack memory bus
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_adr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_good,
    output logic [DATA_W-1:0] data_rdata_o,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_adr_i,
    output logic              instr_good,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    input  logic              mem_busy_i,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, DATA_XFER, INSTR_XFER, RESP} state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    logic        last_instr;   // 1 when the instruction side won the previous grant
    logic [15:0] cnt;          // strobe cycles elapsed without an ack
    logic        xfer_wr;      // current data transfer is a write
    logic        grant_data;
    logic        grant_instr;
    logic        done_ack;
    logic        done_to;
    logic        wr_req;

    // A simultaneous read and write request is served as a read
    assign wr_req = data_write & ~data_read;

    // Next-state selection: arbitration in IDLE, ack/timeout detection while strobing
    always_comb begin
        state_next  = state;
        grant_data  = 1'b0;
        grant_instr = 1'b0;
        done_ack    = 1'b0;
        done_to     = 1'b0;
        case (state)
            IDLE: begin
                if (!mem_busy_i) begin
                    if ((data_read | data_write) && (!instr_req || last_instr)) begin
                        grant_data = 1'b1;
                        state_next = DATA_XFER;
                    end else if (instr_req) begin
                        grant_instr = 1'b1;
                        state_next  = INSTR_XFER;
                    end
                end
            end
            DATA_XFER, INSTR_XFER: begin
                // Ack takes precedence over a timeout landing on the same edge
                if (mem_ack_i) begin
                    done_ack   = 1'b1;
                    state_next = RESP;
                end else if (cnt + 16'd1 >= TO_LIM) begin
                    done_to    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus strobes, latched request fields, returned data and completion pulses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_instr   <= 1'b1;
            cnt          <= '0;
            xfer_wr      <= 1'b0;
            mem_adr_o    <= '0;
            mem_wdata_o  <= '0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            data_good    <= 1'b0;
            instr_good   <= 1'b0;
            data_rdata_o <= '0;
            instr_o      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            data_good  <= 1'b0;
            instr_good <= 1'b0;
            if (grant_data || grant_instr) begin
                cnt         <= '0;
                last_instr  <= grant_instr;
                xfer_wr     <= grant_data & wr_req;
                mem_adr_o   <= grant_data ? data_adr_i : instr_adr_i;
                mem_wdata_o <= (grant_data && wr_req) ? data_wdata_i : '0;
                mem_read_o  <= ~(grant_data & wr_req);
                mem_write_o <= grant_data & wr_req;
            end
            if (state == DATA_XFER || state == INSTR_XFER) begin
                if (done_ack || done_to) begin
                    mem_read_o  <= 1'b0;
                    mem_write_o <= 1'b0;
                    if (state == DATA_XFER) begin
                        data_good    <= 1'b1;
                        data_rdata_o <= (done_ack && !xfer_wr) ? mem_rdata_i : '0;
                    end else begin
                        instr_good <= 1'b1;
                        instr_o    <= done_ack ? mem_rdata_i : '0;
                    end
                    if (done_to) begin
                        timeout_err <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - transaction-level self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        data_read, data_write, instr_req;
    logic [31:0] data_adr_i, data_wdata_i, instr_adr_i;
    logic        data_good, instr_good;
    logic [31:0] data_rdata_o, instr_o;
    logic [31:0] mem_adr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_read_o, mem_write_o, mem_ack_i, mem_busy_i, timeout_err;

    int passed = 0;
    int total  = 0;

    // Reference state: who won last, sticky error, last value returned to each side
    bit          m_last_instr;
    bit          m_terr;
    logic [31:0] m_drd;
    logic [31:0] m_ins;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst),
        .data_read(data_read), .data_write(data_write),
        .data_adr_i(data_adr_i), .data_wdata_i(data_wdata_i),
        .data_good(data_good), .data_rdata_o(data_rdata_o),
        .instr_req(instr_req), .instr_adr_i(instr_adr_i),
        .instr_good(instr_good), .instr_o(instr_o),
        .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .mem_busy_i(mem_busy_i), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobe"}, {62'd0, mem_read_o, mem_write_o}, 64'd0);
        chk({tag, "_good"}, {62'd0, data_good, instr_good}, 64'd0);
    endtask

    // One complete transaction. Called at a negedge with the DUT idle; returns
    // at a negedge with the DUT idle again. ack_dly is the strobe cycle on which
    // ack is presented; values above TO mean the bus never answers.
    task automatic run_txn(input bit dr, input bit dw, input bit ir,
                           input logic [31:0] dadr, input logic [31:0] iadr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int busy_cyc, input int ack_dly);
        bit win_data;
        bit is_wr;
        bit acked;
        int strobes;
        win_data = (dr | dw) && (!ir || m_last_instr);
        is_wr    = dw && !dr;
        strobes  = (ack_dly < TO) ? ack_dly : TO;
        acked    = (ack_dly <= TO);

        data_read = dr; data_write = dw; data_adr_i = dadr; data_wdata_i = wd;
        instr_req = ir; instr_adr_i = iadr;
        mem_ack_i = 1'b0; mem_busy_i = (busy_cyc > 0);
        for (int b = 0; b < busy_cyc; b++) begin
            @(posedge clk); @(negedge clk);
            chk_quiet("busy");
            if (b == busy_cyc - 1) mem_busy_i = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        m_last_instr = !win_data;

        for (int c = 1; c <= strobes; c++) begin
            chk("rd_strobe", {63'd0, mem_read_o}, {63'd0, !(win_data && is_wr)});
            chk("wr_strobe", {63'd0, mem_write_o}, {63'd0, win_data && is_wr});
            chk("bus_adr", {32'd0, mem_adr_o}, {32'd0, win_data ? dadr : iadr});
            chk("bus_wdata", {32'd0, mem_wdata_o}, {32'd0, (win_data && is_wr) ? wd : 32'd0});
            chk("xfer_good", {62'd0, data_good, instr_good}, 64'd0);
            chk("xfer_terr", {63'd0, timeout_err}, {63'd0, m_terr});
            mem_ack_i   = (c == ack_dly);
            mem_rdata_i = (c == ack_dly) ? rd : $urandom;
            mem_busy_i  = $urandom_range(0, 1);
            @(posedge clk); @(negedge clk);
        end
        mem_ack_i = 1'b0; mem_busy_i = 1'b0;

        if (!acked) m_terr = 1'b1;
        if (win_data) m_drd = (acked && !is_wr) ? rd : 32'd0;
        else          m_ins = acked ? rd : 32'd0;
        chk("resp_strobe", {62'd0, mem_read_o, mem_write_o}, 64'd0);
        chk("data_good", {63'd0, data_good}, {63'd0, win_data});
        chk("instr_good", {63'd0, instr_good}, {63'd0, !win_data});
        chk("data_rdata", {32'd0, data_rdata_o}, {32'd0, m_drd});
        chk("instr_o", {32'd0, instr_o}, {32'd0, m_ins});
        chk("timeout_err", {63'd0, timeout_err}, {63'd0, m_terr});

        data_read = 1'b0; data_write = 1'b0; instr_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_quiet("post_resp");
    endtask

    task automatic reset_model();
        m_last_instr = 1'b1;
        m_terr = 1'b0;
        m_drd = '0;
        m_ins = '0;
    endtask

    initial begin
        bit dr, dw, ir;
        nrst = 1'b0;
        data_read = 0; data_write = 0; instr_req = 0;
        data_adr_i = '0; data_wdata_i = '0; instr_adr_i = '0;
        mem_rdata_i = '0; mem_ack_i = 0; mem_busy_i = 0;
        reset_model();
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_outs", {mem_adr_o, mem_wdata_o | data_rdata_o | instr_o}, 64'd0);
        chk("reset_terr", {63'd0, timeout_err}, 64'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Directed: read with ack on third strobe cycle, then a one-cycle write
        run_txn(1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 3);
        run_txn(0, 1, 0, 32'h0000_0200, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF, 0, 1);
        // Fetch held off by a busy bus
        run_txn(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h1357_9BDF, 5, 2);
        // Both requesters held: grants alternate, data first after a fetch
        for (int k = 0; k < 4; k++)
            run_txn(1, 0, 1, 32'h400 + k, 32'h800 + k, 32'h0, $urandom, 0, 1 + k % 2);
        // Ack on the last allowed cycle completes normally, then a real timeout
        run_txn(1, 0, 0, 32'h0000_0300, 32'h0, 32'h0, 32'h0BAD_F00D, 0, TO);
        run_txn(1, 0, 0, 32'h0000_0304, 32'h0, 32'h0, 32'h5555_AAAA, 0, TO + 3);
        run_txn(0, 0, 1, 32'h0, 32'h0000_0040, 32'h0, 32'h6666_7777, 0, 2);

        // Reset in the middle of a data transfer
        data_read = 1'b1; data_adr_i = 32'h0000_0500;
        @(posedge clk); @(negedge clk);
        chk("mid_strobe", {63'd0, mem_read_o}, 64'd1);
        @(posedge clk); @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk_quiet("mid_reset");
        chk("mid_reset_outs", {mem_adr_o, data_rdata_o | instr_o}, 64'd0);
        chk("mid_reset_terr", {63'd0, timeout_err}, 64'd0);
        data_read = 1'b0;
        reset_model();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk_quiet("after_reset");
        run_txn(1, 0, 0, 32'h0000_0600, 32'h0, 32'h0, 32'hA5A5_5A5A, 0, 2);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            dr = $urandom_range(0, 1);
            dw = $urandom_range(0, 1);
            ir = $urandom_range(0, 1);
            if (!dr && !dw) ir = 1'b1;
            run_txn(dr, dw, ir, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(1, TO + 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
